vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 tb/tb_vga_timing_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, counter types and the four-phase enum used by
// both axis counters.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_t;

  function automatic int axis_total(input int active_len, input int fp_len,
                                    input int sync_len, input int bp_len);
    return active_len + fp_len + sync_len + bp_len;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: position counter, ACTIVE/FP/SYNC/BP phase FSM and wrap flag.
// Sync and active flags are produced from the next phase so the parent can register them.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FP_LEN     = DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BP_LEN     = DEF_H_BP
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output count_t count,
  output logic   wrap,
  output logic   sync_n_next,
  output logic   active_next
);

  localparam int     TOTAL      = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);
  localparam count_t END_ACTIVE = count_t'(ACTIVE_LEN - 1);
  localparam count_t END_FP     = count_t'(ACTIVE_LEN + FP_LEN - 1);
  localparam count_t END_SYNC   = count_t'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam count_t END_TOTAL  = count_t'(TOTAL - 1);

  phase_t phase, phase_next;

  // Wrap is explicit at the configured total, never at the counter's natural rollover.
  assign wrap = en && (count == END_TOTAL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= ACTIVE;
    end else begin
      phase <= phase_next;
    end
  end

  // NOTE: phase_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    phase_next = phase;
    if (en) begin
      unique case (phase)
        ACTIVE: if (count == END_ACTIVE) phase_next = FP;
        FP:     if (count == END_FP)     phase_next = SYNC;
        SYNC:   if (count == END_SYNC)   phase_next = BP;
        BP:     if (count == END_TOTAL)  phase_next = ACTIVE;
      endcase
    end
  end

  always_comb begin
    sync_n_next = (phase_next != SYNC);
    active_next = (phase_next == ACTIVE);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator clocked by clk, advancing one pixel per rising edge of pix_clk_in.
// Optional completed-frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_clk_in,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              line_start,
  output logic              frame_start,
  output logic [15:0]       frame_count
);

  logic   pix_prev;
  logic   pix_tick;
  logic   h_wrap, v_wrap;
  logic   h_sync_n_next, v_sync_n_next;
  logic   h_active_next, v_active_next;
  count_t h_count, v_count;

  // pix_clk_in is treated as data: a tick is its rising edge seen in the clk domain.
  assign pix_tick = pix_clk_in & ~pix_prev;

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP)
  ) u_h_axis (
    .clk         (clk),
    .rst         (rst),
    .en          (pix_tick),
    .count       (h_count),
    .wrap        (h_wrap),
    .sync_n_next (h_sync_n_next),
    .active_next (h_active_next)
  );

  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP)
  ) u_v_axis (
    .clk         (clk),
    .rst         (rst),
    .en          (h_wrap),
    .count       (v_count),
    .wrap        (v_wrap),
    .sync_n_next (v_sync_n_next),
    .active_next (v_active_next)
  );

  assign x = h_count;
  assign y = v_count;

  // Flags are registered from next-phase values so they switch on the same edge as x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_prev    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_prev    <= pix_clk_in;
      hsync       <= h_sync_n_next;
      vsync       <= v_sync_n_next;
      video_on    <= h_active_next & v_active_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster; expected outputs come
// from a tick-count reference model, checked by an independent monitor.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        von;
    logic        ls;
    logic        fs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_clk_in;
  logic        hsync, vsync, video_on, line_start, frame_start;
  logic [9:0]  x, y;
  logic [15:0] frame_count;

  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: pixel index within the frame, last pix sample, frame count.
  int          t = 0;
  bit          prev = 1'b0;
  logic [15:0] fc = '0;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_clk_in  (pix_clk_in),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_view(input bit ls, input bit fs);
    obs_t o;
    int   px, py;
    px    = t % HT;
    py    = t / HT;
    o.x   = 10'(px);
    o.y   = 10'(py);
    o.hs  = !(px >= HA + HF && px < HA + HF + HS);
    o.vs  = !(py >= VA + VF && py < VA + VF + VS);
    o.von = (px < HA) && (py < VA);
    o.ls  = ls;
    o.fs  = fs;
    o.fc  = fc;
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = {hsync, vsync, video_on, line_start, frame_start, x, y, frame_count};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%h | exp x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%h",
               name, $time, got.x, got.y, got.hs, got.vs, got.von, got.ls, got.fs, got.fc,
               exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.ls, exp.fs, exp.fc);
    end
  endtask

  // Drive one clk cycle of stimulus and queue what the outputs must be after the next edge.
  task automatic step(input bit r, input bit v);
    bit ls, fs;
    @(negedge clk);
    rst        = r;
    pix_clk_in = v;
    ls = 1'b0;
    fs = 1'b0;
    if (r) begin
      t    = 0;
      prev = 1'b0;
      fc   = '0;
    end else begin
      if (v && !prev) begin
        t  = (t + 1) % FT;
        ls = (t % HT == 0);
        fs = (t == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (fs) fc = fc + 16'd1;
`endif
      end
      prev = v;
    end
    q.push_back(model_view(ls, fs));
  endtask

  task automatic square(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, (i % 4) < 2);
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst        = 1'b1;
    pix_clk_in = 1'b0;
    #1;
    t    = 0;
    prev = 1'b0;
    fc   = '0;
    check("async_rst", model_view(1'b0, 1'b0));
    q.push_back(model_view(1'b0, 1'b0));
  endtask

  // Monitor: compares the DUT against the oldest queued expectation once per clk.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) check("scoreboard", q.pop_front());
    end
  end

  initial begin
    rst        = 1'b1;
    pix_clk_in = 1'b0;

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

    // Regular pixel clock across more than two frames.
    square(2 * FT * 4 + 40);

    // Random pix_clk_in levels, including single-cycle pulses and long holds.
    for (int i = 0; i < 600; i++) step(1'b0, 1'($urandom_range(0, 1)));

    // Constant high then constant low: no ticks, everything frozen.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++)  step(1'b0, 1'b0);

    // Reach a mid-frame position, then reset asynchronously between edges.
    begin
      int budget;
      budget = 0;
      while (t != 50 && budget < 4 * FT * 4) begin
        step(1'b0, (budget % 4) < 2);
        budget++;
      end
      if (t != 50) begin
        miscompares++;
        $display("FAIL reach_midframe: model position %0d, wanted 50", t);
      end
    end
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    square(FT * 4 + 20);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Preload near rollover and run two more frames to see 0xFFFF then 0x0000.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    fc = 16'hFFFE;
`endif
    square(2 * FT * 4 + 20);

    for (int i = 0; i < 400; i++) step(1'b0, 1'($urandom_range(0, 1)));

    @(posedge clk);
    #2;
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, wanted 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
